// File: rtl/hawk_axi_mem_responder.sv
// AXI4 slave responder for the HAWK masters: one transaction at a time, each
// full-cacheline beat mapped onto a word memory with one cycle of read latency.
module hawk_axi_mem_responder #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned MEM_AW = 20
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BYTES       = DATA_W / 8;
    localparam int unsigned OFF         = $clog2(BYTES);
    localparam logic [2:0]  FULL_SIZE   = 3'(OFF);
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  BURST_WRAP  = 2'b10;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_REQ,
        RD_CAP,
        RD_BEAT
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                fixed_q, fixed_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                last_beat;
    logic [ADDR_W-1:0]   next_addr;
    logic                unused_addr_bits;

    assign last_beat = (cnt_q == len_q);
    assign next_addr = fixed_q ? addr_q : addr_q + ADDR_W'(BYTES);

    assign axi_bid   = id_q;
    assign axi_rid   = id_q;
    assign axi_rdata = rdata_q;
    assign mem_addr  = addr_q[OFF+MEM_AW-1:OFF];

    // Byte offset and bits above the memory window are deliberately dropped.
    assign unused_addr_bits = ^{addr_q[ADDR_W-1:OFF+MEM_AW], addr_q[OFF-1:0]};

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        fixed_d     = fixed_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        axi_awready = 1'b0;
        axi_arready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = RESP_OKAY;
        axi_rvalid  = 1'b0;
        axi_rresp   = RESP_OKAY;
        axi_rlast   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        mem_be      = '0;

        unique case (state_q)
            IDLE: begin
                // Writes win a tie, so AR is only offered while AW is idle.
                axi_awready = 1'b1;
                axi_arready = !axi_awvalid;
                cnt_d       = '0;
                if (axi_awvalid) begin
                    id_d    = axi_awid;
                    addr_d  = axi_awaddr;
                    len_d   = axi_awlen;
                    fixed_d = (axi_awburst == BURST_FIXED);
                    err_d   = (axi_awsize != FULL_SIZE) || (axi_awburst == BURST_WRAP);
                    state_d = WR_DATA;
                end else if (axi_arvalid) begin
                    id_d    = axi_arid;
                    addr_d  = axi_araddr;
                    len_d   = axi_arlen;
                    fixed_d = (axi_arburst == BURST_FIXED);
                    err_d   = (axi_arsize != FULL_SIZE) || (axi_arburst == BURST_WRAP);
                    state_d = RD_REQ;
                end
            end
            WR_DATA: begin
                axi_wready = 1'b1;
                if (axi_wvalid) begin
                    mem_req   = !err_q;
                    mem_we    = !err_q;
                    mem_wdata = axi_wdata;
                    mem_be    = axi_wstrb;
                    if (axi_wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    // The beat count, not wlast, decides where the burst ends.
                    if (last_beat) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            WR_RESP: begin
                axi_bvalid = 1'b1;
                axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (axi_bready) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                mem_req = !err_q;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                rdata_d = err_q ? '0 : mem_rdata;
                state_d = RD_BEAT;
            end
            RD_BEAT: begin
                axi_rvalid = 1'b1;
                axi_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                axi_rlast  = last_beat;
                if (axi_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            fixed_q <= fixed_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
